// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port stand-in: I2C write responder decoding {reg, data}.
// Optional shadow register file enabled by defining WM8731_SHADOW_EN.
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       reg_wr,
  output logic       busy,
  output logic       bus_err
`ifdef WM8731_SHADOW_EN
  ,
  input  logic [3:0] shadow_raddr,
  output logic [8:0] shadow_rdata
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK0,
    S_BYTE1,
    S_ACK1,
    S_BYTE2,
    S_ACK2,
    S_WSTOP
  } state_t;

  logic [SYNC_STG-1:0] r_scl_sync;
  logic [SYNC_STG-1:0] r_sda_sync;
  logic                r_scl_prev;
  logic                r_sda_prev;

  state_t              r_state;
  logic   [3:0]        r_bit;
  logic   [7:0]        r_shift;
  logic   [7:0]        r_byte1;
  logic                r_oe;
  logic                r_busy;
  logic                r_mine;
  logic                r_err_done;
  logic   [6:0]        r_reg_addr;
  logic   [8:0]        r_reg_data;
  logic                r_reg_wr;
  logic                r_bus_err;

  state_t              w_state_nxt;
  logic   [3:0]        w_bit_nxt;
  logic   [7:0]        w_shift_nxt;
  logic   [7:0]        w_byte1_nxt;
  logic                w_oe_nxt;
  logic                w_busy_nxt;
  logic                w_mine_nxt;
  logic                w_err_done_nxt;
  logic   [6:0]        w_addr_nxt;
  logic   [8:0]        w_data_nxt;
  logic                w_wr_nxt;
  logic                w_err_nxt;

  logic                w_scl;
  logic                w_sda;
  logic                w_rise;
  logic                w_fall;
  logic                w_start;
  logic                w_stop;
  logic                w_byte_done;
  logic                w_match;

  // Bring the asynchronous bus lines into the clock domain; idle is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], i2c_sclk};
      r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], i2c_sdat_in};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl   = r_scl_sync[SYNC_STG-1];
  assign w_sda   = r_sda_sync[SYNC_STG-1];
  assign w_rise  = w_scl & ~r_scl_prev;
  assign w_fall  = ~w_scl & r_scl_prev;
  assign w_start = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  assign w_byte_done = w_fall && (r_bit == 4'd8);
  assign w_match     = (r_shift[7:1] == DEV_ADDR);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_shift    <= '0;
      r_byte1    <= '0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_mine     <= 1'b0;
      r_err_done <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_reg_wr   <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_byte1    <= w_byte1_nxt;
      r_oe       <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_mine     <= w_mine_nxt;
      r_err_done <= w_err_done_nxt;
      r_reg_addr <= w_addr_nxt;
      r_reg_data <= w_data_nxt;
      r_reg_wr   <= w_wr_nxt;
      r_bus_err  <= w_err_nxt;
    end
  end

  // Bus events drive the transfer FSM; START/STOP override bit activity.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_byte1_nxt    = r_byte1;
    w_oe_nxt       = r_oe;
    w_busy_nxt     = r_busy;
    w_mine_nxt     = r_mine;
    w_err_done_nxt = r_err_done;
    w_addr_nxt     = r_reg_addr;
    w_data_nxt     = r_reg_data;
    w_wr_nxt       = 1'b0;
    w_err_nxt      = 1'b0;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_bit_nxt   = '0;
      w_err_nxt   = (r_state != S_IDLE) && (r_state != S_WSTOP);
    end else if (w_start) begin
      w_state_nxt    = S_ADDR;
      w_busy_nxt     = 1'b1;
      w_oe_nxt       = 1'b0;
      w_bit_nxt      = '0;
      w_mine_nxt     = 1'b0;
      w_err_done_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_ADDR: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_bit_nxt   = r_bit + 4'd1;
          end else if (w_byte_done) begin
            w_bit_nxt = '0;
            if (w_match && !r_shift[0]) begin
              w_oe_nxt    = 1'b1;
              w_state_nxt = S_ACK0;
            end else begin
              // NACK; the pending ACK slot is skipped by presetting 8.
              w_state_nxt = S_WSTOP;
              w_bit_nxt   = 4'd8;
              w_err_nxt   = w_match & r_shift[0];
            end
          end
        end
        S_ACK0: begin
          if (w_fall) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_BYTE1;
          end
        end
        S_BYTE1: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_bit_nxt   = r_bit + 4'd1;
          end else if (w_byte_done) begin
            w_bit_nxt   = '0;
            w_byte1_nxt = r_shift;
            w_oe_nxt    = 1'b1;
            w_state_nxt = S_ACK1;
          end
        end
        S_ACK1: begin
          if (w_fall) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_BYTE2;
          end
        end
        S_BYTE2: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_bit_nxt   = r_bit + 4'd1;
          end else if (w_byte_done) begin
            w_bit_nxt   = '0;
            w_oe_nxt    = 1'b1;
            w_state_nxt = S_ACK2;
          end
        end
        S_ACK2: begin
          if (w_fall) begin
            w_oe_nxt    = 1'b0;
            w_addr_nxt  = r_byte1[7:1];
            w_data_nxt  = {r_byte1[0], r_shift};
            w_wr_nxt    = 1'b1;
            w_mine_nxt  = 1'b1;
            w_bit_nxt   = '0;
            w_state_nxt = S_WSTOP;
          end
        end
        S_WSTOP: begin
          if (w_rise) begin
            w_bit_nxt = (r_bit == 4'd8) ? 4'd0 : r_bit + 4'd1;
          end else if (w_byte_done && r_mine && !r_err_done) begin
            w_err_nxt      = 1'b1;
            w_err_done_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign i2c_sdat_oe = r_oe;
  assign reg_addr    = r_reg_addr;
  assign reg_data    = r_reg_data;
  assign reg_wr      = r_reg_wr;
  assign busy        = r_busy;
  assign bus_err     = r_bus_err;

`ifdef WM8731_SHADOW_EN
  localparam logic [8:0] SHADOW_DEF [10] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  logic [8:0] r_shadow [10];

  // Shadow copy tracks writes in the same clock as the reg_wr pulse.
  always_ff @(posedge clk) begin
    if (reset || (w_wr_nxt && (w_addr_nxt == 7'h0F))) begin
      for (int i = 0; i < 10; i++) begin
        r_shadow[i] <= SHADOW_DEF[i];
      end
    end else if (w_wr_nxt && (w_addr_nxt < 7'd10)) begin
      r_shadow[w_addr_nxt[3:0]] <= w_data_nxt;
    end
  end

  assign shadow_rdata = (shadow_raddr < 4'd10) ?
                        r_shadow[shadow_raddr] : 9'h000;
`endif

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder: bit-banged I2C master.
// Shadow checks run only when WM8731_SHADOW_EN is defined.
module tb_wm8731_i2c_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       ack_slot = 1'b0;
  logic       bus_sda;
  logic       oe;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_wr;
  logic       busy;
  logic       bus_err;
`ifdef WM8731_SHADOW_EN
  logic [3:0] shadow_raddr = 4'd0;
  logic [8:0] shadow_rdata;
`endif

  int errors = 0;
  int checks = 0;
  int n_wr = 0;
  int n_err = 0;
  int n_oe = 0;
  int n_viol = 0;

  assign bus_sda = m_sda & ~oe;

  always #5 clk = ~clk;

  wm8731_i2c_responder dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (m_scl),
    .i2c_sdat_in (bus_sda),
    .i2c_sdat_oe (oe),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .reg_wr      (reg_wr),
    .busy        (busy),
    .bus_err     (bus_err)
`ifdef WM8731_SHADOW_EN
    ,
    .shadow_raddr(shadow_raddr),
    .shadow_rdata(shadow_rdata)
`endif
  );

  always @(negedge clk) begin
    if (reg_wr) n_wr++;
    if (bus_err) n_err++;
    if (oe) n_oe++;
    if (oe && m_scl && !ack_slot) n_viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(8);
    m_sda = 1'b0;
    tick(8);
    m_scl = 1'b0;
    tick(4);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0;
    tick(4);
    m_scl = 1'b1;
    tick(8);
    m_sda = 1'b1;
    tick(8);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i];
      tick(4);
      m_scl = 1'b1;
      tick(8);
      m_scl = 1'b0;
      tick(4);
    end
    m_sda = 1'b1;
    ack_slot = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(4);
    ack = (bus_sda === 1'b0);
    tick(4);
    m_scl = 1'b0;
    tick(4);
    ack_slot = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(4);
    checks++;
    if (oe !== 1'b0) begin
      errors++; $display("FAIL rst_oe got %b want 0", oe);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (reg_wr !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rst_pulses got %b%b want 00", reg_wr, bus_err);
    end
    checks++;
    if (reg_addr !== 7'h00 || reg_data !== 9'h000) begin
      errors++; $display("FAIL rst_regs got %h/%h want 00/000", reg_addr, reg_data);
    end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_write;
    int w0, e0, v0;
    logic a0, a1, a2;
    w0 = n_wr; e0 = n_err; v0 = n_viol;
    i2c_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL wr_busy_on got %b want 1", busy);
    end
    i2c_byte(8'h34, a0);
    i2c_byte(8'h08, a1);
    i2c_byte(8'h12, a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      errors++; $display("FAIL wr_acks got %b want 111", {a0, a1, a2});
    end
    checks++;
    if (n_wr - w0 != 1) begin
      errors++; $display("FAIL wr_count got %0d want 1", n_wr - w0);
    end
    checks++;
    if (reg_addr !== 7'h04 || reg_data !== 9'h012) begin
      errors++; $display("FAIL wr_regs got %h/%h want 04/012", reg_addr, reg_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_busy_off got %b want 0", busy);
    end
    checks++;
    if (n_err - e0 != 0) begin
      errors++; $display("FAIL wr_err got %0d want 0", n_err - e0);
    end
    checks++;
    if (n_viol - v0 != 0) begin
      errors++; $display("FAIL wr_oe_scl_high got %0d want 0", n_viol - v0);
    end
  endtask

  task automatic test_nack;
    int w0, o0;
    logic a0, a1;
    w0 = n_wr; o0 = n_oe;
    i2c_start();
    i2c_byte(8'h36, a0);
    i2c_byte(8'h08, a1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL nack_busy_on got %b want 1", busy);
    end
    i2c_stop();
    checks++;
    if ({a0, a1} !== 2'b00) begin
      errors++; $display("FAIL nack_acks got %b want 00", {a0, a1});
    end
    checks++;
    if (n_oe - o0 != 0) begin
      errors++; $display("FAIL nack_oe got %0d want 0", n_oe - o0);
    end
    checks++;
    if (n_wr - w0 != 0) begin
      errors++; $display("FAIL nack_wr got %0d want 0", n_wr - w0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL nack_busy_off got %b want 0", busy);
    end
    checks++;
    if (reg_addr !== 7'h04 || reg_data !== 9'h012) begin
      errors++; $display("FAIL nack_hold got %h/%h want 04/012", reg_addr, reg_data);
    end
  endtask

  task automatic test_short;
    int w0, e0;
    logic a0, a1;
    w0 = n_wr; e0 = n_err;
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h08, a1);
    i2c_stop();
    checks++;
    if ({a0, a1} !== 2'b11) begin
      errors++; $display("FAIL short_acks got %b want 11", {a0, a1});
    end
    checks++;
    if (n_wr - w0 != 0) begin
      errors++; $display("FAIL short_wr got %0d want 0", n_wr - w0);
    end
    checks++;
    if (n_err - e0 != 1) begin
      errors++; $display("FAIL short_err got %0d want 1", n_err - e0);
    end
  endtask

  task automatic test_back_to_back;
    int w0, e0;
    logic a0, a1, a2, a3, a4;
    w0 = n_wr; e0 = n_err;
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0E, a1);
    i2c_start();
    i2c_byte(8'h34, a2);
    i2c_byte(8'h0E, a3);
    i2c_byte(8'h4A, a4);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3, a4} !== 5'b11111) begin
      errors++; $display("FAIL sr_acks got %b want 11111", {a0, a1, a2, a3, a4});
    end
    checks++;
    if (n_wr - w0 != 1) begin
      errors++; $display("FAIL sr_wr got %0d want 1", n_wr - w0);
    end
    checks++;
    if (reg_addr !== 7'h07 || reg_data !== 9'h04A) begin
      errors++; $display("FAIL sr_regs got %h/%h want 07/04A", reg_addr, reg_data);
    end
    checks++;
    if (n_err - e0 != 0) begin
      errors++; $display("FAIL sr_err got %0d want 0", n_err - e0);
    end
  endtask

  task automatic test_extra;
    int w0, e0;
    logic a0, a1, a2, a3;
    w0 = n_wr; e0 = n_err;
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h08, a1);
    i2c_byte(8'h12, a2);
    checks++;
    if (n_wr - w0 != 1) begin
      errors++; $display("FAIL extra_wr_early got %0d want 1", n_wr - w0);
    end
    i2c_byte(8'h55, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1110) begin
      errors++; $display("FAIL extra_acks got %b want 1110", {a0, a1, a2, a3});
    end
    checks++;
    if (n_wr - w0 != 1) begin
      errors++; $display("FAIL extra_wr got %0d want 1", n_wr - w0);
    end
    checks++;
    if (n_err - e0 != 1) begin
      errors++; $display("FAIL extra_err got %0d want 1", n_err - e0);
    end
    checks++;
    if (reg_addr !== 7'h04 || reg_data !== 9'h012) begin
      errors++; $display("FAIL extra_regs got %h/%h want 04/012", reg_addr, reg_data);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    logic a0, a1, a2;
    logic [7:0] b;
    i2c_start();
    i2c_byte(8'h34, a0);
    b = 8'h0E;
    for (int i = 7; i >= 5; i--) begin
      m_sda = b[i];
      tick(4);
      m_scl = 1'b1;
      tick(8);
      m_scl = 1'b0;
      tick(4);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy_pre got %b want 1", busy);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst got oe=%b busy=%b want 0 0", oe, busy);
    end
    checks++;
    if (reg_addr !== 7'h00 || reg_data !== 9'h000) begin
      errors++; $display("FAIL mid_rst_regs got %h/%h want 00/000", reg_addr, reg_data);
    end
    reset = 1'b0;
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(8);
    w0 = n_wr;
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h10, a1);
    i2c_byte(8'h1F, a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b111 || n_wr - w0 != 1) begin
      errors++; $display("FAIL mid_clean got acks=%b wr=%0d want 111 1", {a0, a1, a2}, n_wr - w0);
    end
    checks++;
    if (reg_addr !== 7'h08 || reg_data !== 9'h01F) begin
      errors++; $display("FAIL mid_regs got %h/%h want 08/01F", reg_addr, reg_data);
    end
  endtask

`ifdef WM8731_SHADOW_EN
  task automatic test_shadow;
    logic a0, a1, a2;
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0A, a1);
    i2c_byte(8'h05, a2);
    i2c_stop();
    shadow_raddr = 4'd5;
    tick(1);
    checks++;
    if (shadow_rdata !== 9'h005) begin
      errors++; $display("FAIL shadow_wr got %h want 005", shadow_rdata);
    end
    shadow_raddr = 4'd8;
    tick(1);
    checks++;
    if (shadow_rdata !== 9'h01F) begin
      errors++; $display("FAIL shadow_r8 got %h want 01F", shadow_rdata);
    end
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h1E, a1);
    i2c_byte(8'h00, a2);
    i2c_stop();
    shadow_raddr = 4'd5;
    tick(1);
    checks++;
    if (shadow_rdata !== 9'h008) begin
      errors++; $display("FAIL shadow_def5 got %h want 008", shadow_rdata);
    end
    shadow_raddr = 4'd8;
    tick(1);
    checks++;
    if (shadow_rdata !== 9'h000) begin
      errors++; $display("FAIL shadow_def8 got %h want 000", shadow_rdata);
    end
    shadow_raddr = 4'd12;
    tick(1);
    checks++;
    if (shadow_rdata !== 9'h000) begin
      errors++; $display("FAIL shadow_oob got %h want 000", shadow_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_short();
    test_back_to_back();
    test_extra();
    test_reset_mid();
`ifdef WM8731_SHADOW_EN
    test_shadow();
`endif
    checks++;
    if (n_viol != 0) begin
      errors++; $display("FAIL oe_scl_high got %0d want 0", n_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
